// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory handshake and IF/ID-side signals of the fetch stage
interface fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  modport master (
    input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, pc_out, instr_out, valid_out
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, pc_out, instr_out, valid_out
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, imem handshake, skid on stall, squash on redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    drop_addr_d   = drop_addr_q;
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc_q;
    bus.valid_out = 1'b0;
    bus.instr_out = NOP;
    bus.pc_out    = pc_plus4;

    unique case (state_q)
      FETCH: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = pc_q;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          // A request that has not completed is still owed a response; wait it out in DROP.
          if (!bus.imem_ready) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (bus.imem_ready) begin
          bus.valid_out = 1'b1;
          bus.instr_out = bus.imem_rdata;
          pc_d          = pc_plus4;
          if (bus.stall) begin
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = pc_plus4;
            state_d      = HOLD;
          end
        end
      end

      HOLD: begin
        bus.pc_out = skid_pc_q;
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end else begin
          bus.valid_out = 1'b1;
          bus.instr_out = skid_instr_q;
          if (!bus.stall) begin
            state_d = FETCH;
          end
        end
      end

      DROP: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = drop_addr_q;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.imem_ready) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP;
      skid_pc_q    <= 32'd0;
      drop_addr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      drop_addr_q  <= drop_addr_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and runs the instruction-memory request/ready handshake.
- Drives the pc/instr inputs of the IF/ID pipeline buffer, which it writes into.
- Honours that buffer's stall (hold) signal using an internal skid register, and squashes on branch/jump redirect.
- When no instruction is available it presents a NOP, because the IF/ID buffer captures every non-stalled cycle.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP, 32'h00000000, instruction word presented when valid_out=0 (sll $0,$0,0).

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high.
stall  input  1  1 = IF/ID buffer holding this cycle (same signal as the buffer's load/hold input).
redirect  input  1  1 = taken branch/jump; squash the current fetch.
redirect_pc  input  32  new fetch address, valid when redirect=1.
imem_req  output  1  memory request.
imem_addr  output  32  request address; stable while imem_req=1 and imem_ready=0.
imem_ready  input  1  response valid this cycle; completes the request at the clock edge.
imem_rdata  input  32  instruction word, valid when imem_ready=1.
pc_out  output  32  PC+4 of the presented instruction (to IF/ID pc_in).
instr_out  output  32  presented instruction (to IF/ID instr_in); NOP when valid_out=0.
valid_out  output  1  presented instruction is real.

Behaviour:
- Registers: pc[31:0], state, skid_instr[31:0], skid_pc[31:0], drop_addr[31:0].
- Reset (async, any state, including mid-request): pc=RESET_PC, state=FETCH, skid_instr=NOP, skid_pc=0, drop_addr=0.
- Outputs are combinational from state and inputs. Zero-wait memory gives 0-cycle fetch-to-output latency.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 0. Addresses are not checked for alignment.
- Redirect has priority over stall and over imem_ready in every state. In a redirect cycle valid_out=0 and instr_out=NOP.

FETCH state:
- imem_req=1, imem_addr=pc.
- redirect=1: pc<=redirect_pc.
  - If imem_ready=1, the response is discarded; stay in FETCH.
  - If imem_ready=0: drop_addr<=pc, go to DROP.
- Else if imem_ready=1: valid_out=1, instr_out=imem_rdata, pc_out=pc+4, pc<=pc+4.
  - stall=0: stay in FETCH.
  - stall=1: skid_instr<=imem_rdata, skid_pc<=pc+4, go to HOLD.
- Else (imem_ready=0): valid_out=0, instr_out=NOP, pc_out=pc+4, pc unchanged.

HOLD state:
- imem_req=0. valid_out=1, instr_out=skid_instr, pc_out=skid_pc.
- redirect=1: pc<=redirect_pc, go to FETCH (outputs squashed).
- Else if stall=0: go to FETCH. The buffer captures the skid contents this cycle.
- Else stay in HOLD; skid is unchanged for any stall length.

DROP state (orphaned request still outstanding):
- imem_req=1, imem_addr=drop_addr (held stable), valid_out=0, instr_out=NOP, pc_out=pc+4.
- imem_ready=1: response discarded, go to FETCH.
- redirect=1 in DROP: pc<=redirect_pc, stay in DROP until the response arrives.

General rules:
- No instruction is ever presented twice to a non-stalled buffer.
- No instruction is lost across a stall.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory returning addr|32'hA0000000 -> valid_out=1 every cycle; pc_out 4,8,12; instr_out A0000000, A0000004, A0000008; imem_addr 0,4,8.
- Memory with 2 wait states -> two cycles valid_out=0/instr_out=NOP and imem_addr held at 0, then instr A0000000; next imem_addr=4.
- stall=1 for 3 cycles on the cycle instr A0000004 returns -> HOLD. imem_req=0, instr_out stays A0000004 with pc_out=8 for 3 cycles. On release the next fetch address is 8 and there is no duplicate.
- redirect=1 with redirect_pc=32'h100 while a 3-wait request to 8 is outstanding -> DROP. imem_addr stays 8 until ready, valid_out=0 throughout; then fetch from 0x100, instr A0000100, pc_out 0x104.
- redirect and stall asserted together in HOLD -> outputs NOP/valid 0 that cycle; next state FETCH at redirect_pc.
- Assert reset mid-wait in DROP and at pc=32'hFFFFFFFC -> immediate return to FETCH at RESET_PC. Separately, without reset, a fetch at FFFFFFFC gives pc_out=0 and a next address of 0.
